// File: rtl/load_store_unit_if.sv
// Bus bundle between the execute stage, the load/store unit and data memory.
// master: the execute stage / memory side (drives requests and memory read data).
// slave:  the load/store unit (drives ready, responses and memory strobes).
interface load_store_unit_if;
  logic        C_ReqValid;
  logic        C_ReqReady;
  logic        C_ReqWrite;
  logic        C_ReqByte;
  logic        C_ReqSigned;
  logic [15:0] A_ReqAddress;
  logic [15:0] D_ReqWData;
  logic        C_RespValid;
  logic [15:0] D_RespData;
  logic        C_RespError;
  logic [15:0] A_DataAddress;
  logic [15:0] D_WriteData;
  logic        C_DMRead;
  logic        C_DMWrite;
  logic [15:0] D_Data;

  modport master (
    output C_ReqValid, C_ReqWrite, C_ReqByte, C_ReqSigned, A_ReqAddress, D_ReqWData,
    output D_Data,
    input  C_ReqReady, C_RespValid, D_RespData, C_RespError,
    input  A_DataAddress, D_WriteData, C_DMRead, C_DMWrite
  );

  modport slave (
    input  C_ReqValid, C_ReqWrite, C_ReqByte, C_ReqSigned, A_ReqAddress, D_ReqWData,
    input  D_Data,
    output C_ReqReady, C_RespValid, D_RespData, C_RespError,
    output A_DataAddress, D_WriteData, C_DMRead, C_DMWrite
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage byte-addressed loads/stores into
// 16-bit-word data memory accesses. Byte stores are read-modify-write.
// Optional feature macro: LSU_BOUNDS_CHECK_EN (word address >= MEM_WORDS
// is answered with an error and no memory access).
module load_store_unit #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MEM_WORDS   = 8192
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] data_addr_q, data_addr_d;
  logic [15:0] write_data_q, write_data_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;

  // Latched request fields (pure data, no reset needed)
  logic        write_q, write_d;
  logic        byte_q, byte_d;
  logic        signed_q, signed_d;
  logic        lane_q, lane_d;
  logic [7:0]  wbyte_q, wbyte_d;

  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_err;

  // Extract the addressed byte lane and extend it, or pass the whole word.
  function automatic logic [15:0] load_result(input logic [15:0] word,
                                              input logic        is_byte,
                                              input logic        is_signed,
                                              input logic        lane);
    logic [7:0] b;
    b = lane ? word[15:8] : word[7:0];
    if (!is_byte)
      return word;
    else if (is_signed)
      return {{8{b[7]}}, b};
    else
      return {8'h00, b};
  endfunction

  // Replace the addressed byte lane of the captured word with the store byte.
  function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                             input logic [7:0]  b,
                                             input logic        lane);
    return lane ? {b, word[7:0]} : {word[15:8], b};
  endfunction

  assign req_misaligned = !bus.C_ReqByte && bus.A_ReqAddress[0];

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic [16:0] MEM_LIMIT = 17'(MEM_WORDS);
  assign req_out_of_range = ({2'b00, bus.A_ReqAddress[15:1]} >= MEM_LIMIT);
`else
  assign req_out_of_range = 1'b0;
`endif

  assign req_err = req_misaligned || req_out_of_range;

  // Outputs: strobes and ready are killed combinationally during reset.
  assign bus.C_ReqReady    = (state_q == IDLE)  && !rst;
  assign bus.C_DMRead      = (state_q == READ)  && !rst;
  assign bus.C_DMWrite     = (state_q == WRITE) && !rst;
  assign bus.C_RespValid   = (state_q == RESP)  && !rst;
  assign bus.D_RespData    = resp_data_q;
  assign bus.C_RespError   = resp_error_q;
  assign bus.A_DataAddress = data_addr_q;
  assign bus.D_WriteData   = write_data_q;

  // Next-state and datapath updates for the IDLE/READ/WRITE/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_addr_d  = data_addr_q;
    write_data_d = write_data_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    write_d      = write_q;
    byte_d       = byte_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    wbyte_d      = wbyte_q;

    case (state_q)
      IDLE: begin
        if (bus.C_ReqValid) begin
          write_d     = bus.C_ReqWrite;
          byte_d      = bus.C_ReqByte;
          signed_d    = bus.C_ReqSigned;
          lane_d      = bus.A_ReqAddress[0];
          wbyte_d     = bus.D_ReqWData[7:0];
          data_addr_d = {1'b0, bus.A_ReqAddress[15:1]};
          if (req_err) begin
            state_d      = RESP;
            resp_error_d = 1'b1;
            resp_data_d  = 16'h0000;
          end else if (bus.C_ReqWrite && !bus.C_ReqByte) begin
            state_d      = WRITE;
            write_data_d = bus.D_ReqWData;
          end else begin
            state_d = READ;
            cnt_d   = WAIT_INIT;
          end
        end
      end

      READ: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (write_q) begin
          write_data_d = merge_byte(bus.D_Data, wbyte_q, lane_q);
          state_d      = WRITE;
        end else begin
          resp_data_d  = load_result(bus.D_Data, byte_q, signed_q, lane_q);
          resp_error_d = 1'b0;
          state_d      = RESP;
        end
      end

      WRITE: begin
        resp_data_d  = 16'h0000;
        resp_error_d = 1'b0;
        state_d      = RESP;
      end

      RESP: begin
        resp_data_d  = 16'h0000;
        resp_error_d = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state and externally visible registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      data_addr_q  <= 16'h0000;
      write_data_q <= 16'h0000;
      resp_data_q  <= 16'h0000;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_addr_q  <= data_addr_d;
      write_data_q <= write_data_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Latched request fields; only meaningful after an accept.
  always_ff @(posedge clk) begin
    write_q  <= write_d;
    byte_q   <= byte_d;
    signed_q <= signed_d;
    lane_q   <= lane_d;
    wbyte_q  <= wbyte_d;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic compared against a byte-addressed reference memory model.
module tb_load_store_unit;
  localparam int WS = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  load_store_unit_if bus();

  load_store_unit #(.WAIT_STATES(WS), .MEM_WORDS(8192)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Data memory with WS wait states: data is only valid on the last read cycle.
  logic [15:0] mem [0:65535];
  logic        mem_clr = 1'b0;
  int          rd_cnt = 0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
    end else if (bus.C_DMWrite) begin
      mem[bus.A_DataAddress] <= bus.D_WriteData;
    end
    rd_cnt <= bus.C_DMRead ? rd_cnt + 1 : 0;
  end

  assign bus.D_Data = (bus.C_DMRead && rd_cnt == WS) ? mem[bus.A_DataAddress] : 16'h5A5A;

  // Reference model: sparse word store, unwritten words read as zero.
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_word(input int wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : 16'h0000;
  endfunction

  function automatic bit ref_err(input bit bt, input logic [15:0] addr);
    bit e;
    e = !bt && (addr % 2 == 1);
`ifdef LSU_BOUNDS_CHECK_EN
    if (int'(addr) / 2 >= 8192) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [15:0] ref_load(input bit bt, input bit sg, input logic [15:0] addr);
    int w, b;
    w = int'(ref_word(int'(addr) / 2));
    if (!bt) return 16'(w);
    b = (w >> (8 * (int'(addr) % 2))) & 255;
    if (sg && b >= 128) b = b - 256;
    return 16'(b);
  endfunction

  function automatic logic [15:0] ref_store_word(input bit bt, input logic [15:0] addr, input logic [15:0] wd);
    int w, sh;
    if (!bt) return wd;
    w  = int'(ref_word(int'(addr) / 2));
    sh = 8 * (int'(addr) % 2);
    w  = (w & ~(255 << sh)) | ((int'(wd) & 255) << sh);
    return 16'(w);
  endfunction

  task automatic ref_apply(input bit wr, input bit bt, input logic [15:0] addr, input logic [15:0] wd);
    if (wr && !ref_err(bt, addr)) ref_mem[int'(addr) / 2] = ref_store_word(bt, addr, wd);
  endtask

  function automatic int ref_cycles(input bit wr, input bit bt, input logic [15:0] addr);
    if (ref_err(bt, addr)) return 1;
    if (wr && !bt) return 2;
    if (wr) return WS + 3;
    return WS + 2;
  endfunction

  // Drive one request, then observe the whole transaction until the response.
  task automatic do_req(input bit wr, input bit bt, input bit sg,
                        input logic [15:0] addr, input logic [15:0] wd,
                        output logic [15:0] rdata, output bit rerr, output int cyc,
                        output bit saw_rd, output bit saw_wr, output bit bad_addr,
                        output bit strobe_bad, output logic [15:0] wseen, output bit tmo);
    int  w;
    bit  done;
    rdata = 16'h0; rerr = 0; cyc = 0; saw_rd = 0; saw_wr = 0;
    bad_addr = 0; strobe_bad = 0; wseen = 16'h0; tmo = 0;
    @(negedge clk);
    bus.C_ReqValid = 1'b1; bus.C_ReqWrite = wr; bus.C_ReqByte = bt;
    bus.C_ReqSigned = sg; bus.A_ReqAddress = addr; bus.D_ReqWData = wd;
    w = 0;
    while (!bus.C_ReqReady && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.C_ReqReady) begin
      tmo = 1;
      bus.C_ReqValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.C_ReqValid   = 1'b0;
    bus.C_ReqWrite   = 1'($urandom);
    bus.C_ReqByte    = 1'($urandom);
    bus.C_ReqSigned  = 1'($urandom);
    bus.A_ReqAddress = 16'($urandom);
    bus.D_ReqWData   = 16'($urandom);
    done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.C_DMRead && bus.C_DMWrite) strobe_bad = 1;
      if (bus.C_DMRead) begin
        saw_rd = 1;
        if (bus.A_DataAddress !== {1'b0, addr[15:1]}) bad_addr = 1;
      end
      if (bus.C_DMWrite) begin
        saw_wr = 1;
        wseen  = bus.D_WriteData;
        if (bus.A_DataAddress !== {1'b0, addr[15:1]}) bad_addr = 1;
      end
      if (bus.C_RespValid) begin
        done  = 1;
        rdata = bus.D_RespData;
        rerr  = bus.C_RespError;
        if (bus.C_DMRead || bus.C_DMWrite) strobe_bad = 1;
      end
    end
    if (!done) tmo = 1;
  endtask

  logic [15:0] r_data, r_wseen;
  bit          r_err, r_rd, r_wr, r_badaddr, r_strobe, r_tmo;
  int          r_cyc;

  task automatic test_reset;
    rst = 1'b1;
    bus.C_ReqValid = 1'b1; bus.C_ReqWrite = 1'b1; bus.C_ReqByte = 1'b0;
    bus.C_ReqSigned = 1'b0; bus.A_ReqAddress = 16'h0002; bus.D_ReqWData = 16'h1234;
    mem_clr = 1'b1;
    @(posedge clk); @(posedge clk);
    mem_clr = 1'b0;
    @(negedge clk);
    checks++; if (bus.C_ReqReady !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", bus.C_ReqReady); end
    checks++; if ({bus.C_DMRead, bus.C_DMWrite} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b exp 00", {bus.C_DMRead, bus.C_DMWrite}); end
    checks++; if (bus.C_RespValid !== 1'b0 || bus.C_RespError !== 1'b0) begin errors++; $display("FAIL rst_resp: got v=%b e=%b exp 0/0", bus.C_RespValid, bus.C_RespError); end
    checks++; if (bus.D_RespData !== 16'h0000) begin errors++; $display("FAIL rst_respdata: got %h exp 0000", bus.D_RespData); end
    checks++; if (bus.A_DataAddress !== 16'h0000 || bus.D_WriteData !== 16'h0000) begin errors++; $display("FAIL rst_memregs: got a=%h d=%h exp 0000/0000", bus.A_DataAddress, bus.D_WriteData); end
    rst = 1'b0;
    bus.C_ReqValid = 1'b0;
    @(negedge clk);
    checks++; if (bus.C_ReqReady !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", bus.C_ReqReady); end
  endtask

  task automatic test_word_access;
    do_req(1, 0, 0, 16'h0002, 16'h0014, r_data, r_err, r_cyc, r_rd, r_wr, r_badaddr, r_strobe, r_wseen, r_tmo);
    ref_apply(1, 0, 16'h0002, 16'h0014);
    checks++; if (r_tmo) begin errors++; $display("FAIL wstore_timeout: got timeout exp response"); end
    checks++; if (r_wr !== 1'b1 || r_rd !== 1'b0 || r_badaddr) begin errors++; $display("FAIL wstore_strobes: got wr=%b rd=%b badaddr=%b exp 1/0/0", r_wr, r_rd, r_badaddr); end
    checks++; if (r_wseen !== 16'h0014) begin errors++; $display("FAIL wstore_wdata: got %h exp 0014", r_wseen); end
    checks++; if (r_err !== 1'b0 || r_cyc != 2) begin errors++; $display("FAIL wstore_resp: got err=%b cyc=%0d exp 0/2", r_err, r_cyc); end
    do_req(0, 0, 0, 16'h0002, 16'h0000, r_data, r_err, r_cyc, r_rd, r_wr, r_badaddr, r_strobe, r_wseen, r_tmo);
    checks++; if (r_data !== 16'h0014 || r_err !== 1'b0) begin errors++; $display("FAIL wload_data: got %h err=%b exp 0014/0", r_data, r_err); end
    checks++; if (r_cyc != WS + 2 || r_tmo) begin errors++; $display("FAIL wload_latency: got %0d exp %0d", r_cyc, WS + 2); end
  endtask

  task automatic test_byte_access;
    do_req(1, 1, 0, 16'h0003, 16'h12AB, r_data, r_err, r_cyc, r_rd, r_wr, r_badaddr, r_strobe, r_wseen, r_tmo);
    ref_apply(1, 1, 16'h0003, 16'h12AB);
    checks++; if (r_wseen !== 16'hAB14 || r_wr !== 1'b1 || r_rd !== 1'b1) begin errors++; $display("FAIL bstore_merge: got %h rd=%b wr=%b exp AB14/1/1", r_wseen, r_rd, r_wr); end
    checks++; if (r_cyc != WS + 3 || r_err !== 1'b0 || r_strobe) begin errors++; $display("FAIL bstore_resp: got cyc=%0d err=%b strobe_bad=%b exp %0d/0/0", r_cyc, r_err, r_strobe, WS + 3); end
    do_req(0, 1, 1, 16'h0003, 16'h0000, r_data, r_err, r_cyc, r_rd, r_wr, r_badaddr, r_strobe, r_wseen, r_tmo);
    checks++; if (r_data !== 16'hFFAB) begin errors++; $display("FAIL bload_signed: got %h exp FFAB", r_data); end
    do_req(0, 1, 0, 16'h0003, 16'h0000, r_data, r_err, r_cyc, r_rd, r_wr, r_badaddr, r_strobe, r_wseen, r_tmo);
    checks++; if (r_data !== 16'h00AB) begin errors++; $display("FAIL bload_unsigned: got %h exp 00AB", r_data); end
    do_req(0, 1, 1, 16'h0002, 16'h0000, r_data, r_err, r_cyc, r_rd, r_wr, r_badaddr, r_strobe, r_wseen, r_tmo);
    checks++; if (r_data !== 16'h0014) begin errors++; $display("FAIL bload_low: got %h exp 0014", r_data); end
  endtask

  task automatic test_misaligned;
    do_req(0, 0, 0, 16'h0005, 16'h0000, r_data, r_err, r_cyc, r_rd, r_wr, r_badaddr, r_strobe, r_wseen, r_tmo);
    checks++; if (r_err !== 1'b1 || r_data !== 16'h0000) begin errors++; $display("FAIL misalign_resp: got err=%b data=%h exp 1/0000", r_err, r_data); end
    checks++; if (r_cyc != 1 || r_rd || r_wr) begin errors++; $display("FAIL misalign_timing: got cyc=%0d rd=%b wr=%b exp 1/0/0", r_cyc, r_rd, r_wr); end
  endtask

  task automatic test_reset_mid;
    bit wr_seen, resp_seen;
    @(negedge clk);
    bus.C_ReqValid = 1'b1; bus.C_ReqWrite = 1'b1; bus.C_ReqByte = 1'b1;
    bus.C_ReqSigned = 1'b0; bus.A_ReqAddress = 16'h0002; bus.D_ReqWData = 16'h0077;
    @(posedge clk);
    #1 bus.C_ReqValid = 1'b0;
    @(negedge clk);
    checks++; if (bus.C_DMRead !== 1'b1) begin errors++; $display("FAIL rstmid_in_read: got %b exp 1", bus.C_DMRead); end
    rst = 1'b1;
    wr_seen = 0; resp_seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.C_DMWrite) wr_seen = 1;
      if (bus.C_RespValid) resp_seen = 1;
      @(negedge clk);
      if (i == 1) rst = 1'b0;
    end
    checks++; if (wr_seen || resp_seen) begin errors++; $display("FAIL rstmid_abandon: got wr=%b resp=%b exp 0/0", wr_seen, resp_seen); end
    do_req(0, 0, 0, 16'h0002, 16'h0000, r_data, r_err, r_cyc, r_rd, r_wr, r_badaddr, r_strobe, r_wseen, r_tmo);
    checks++; if (r_data !== ref_load(0, 0, 16'h0002) || r_tmo) begin errors++; $display("FAIL rstmid_unchanged: got %h exp %h", r_data, ref_load(0, 0, 16'h0002)); end
  endtask

  task automatic test_bounds;
    do_req(0, 0, 0, 16'h4000, 16'h0000, r_data, r_err, r_cyc, r_rd, r_wr, r_badaddr, r_strobe, r_wseen, r_tmo);
`ifdef LSU_BOUNDS_CHECK_EN
    checks++; if (r_err !== 1'b1 || r_rd || r_cyc != 1) begin errors++; $display("FAIL bounds_err: got err=%b rd=%b cyc=%0d exp 1/0/1", r_err, r_rd, r_cyc); end
`else
    checks++; if (r_err !== 1'b0 || !r_rd || r_badaddr) begin errors++; $display("FAIL bounds_pass: got err=%b rd=%b badaddr=%b exp 0/1/0", r_err, r_rd, r_badaddr); end
`endif
  endtask

  task automatic test_random;
    bit          wr, bt, sg, exp_err, exp_rd, exp_wr;
    logic [15:0] addr, wd, exp_data, exp_wd;
    int          exp_cyc;
    for (int n = 0; n < 200; n++) begin
      wr   = 1'($urandom);
      bt   = 1'($urandom);
      sg   = 1'($urandom);
      addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      wd   = 16'($urandom);
      exp_err  = ref_err(bt, addr);
      exp_cyc  = ref_cycles(wr, bt, addr);
      exp_data = (exp_err || wr) ? 16'h0000 : ref_load(bt, sg, addr);
      exp_rd   = !exp_err && (!wr || bt);
      exp_wr   = !exp_err && wr;
      exp_wd   = ref_store_word(bt, addr, wd);
      do_req(wr, bt, sg, addr, wd, r_data, r_err, r_cyc, r_rd, r_wr, r_badaddr, r_strobe, r_wseen, r_tmo);
      ref_apply(wr, bt, addr, wd);
      checks++;
      if (r_tmo || r_data !== exp_data || r_err !== exp_err || r_cyc != exp_cyc) begin
        errors++;
        $display("FAIL rand_resp[%0d] wr=%b bt=%b sg=%b a=%h: got data=%h err=%b cyc=%0d tmo=%b exp %h/%b/%0d",
                 n, wr, bt, sg, addr, r_data, r_err, r_cyc, r_tmo, exp_data, exp_err, exp_cyc);
      end
      checks++;
      if (r_rd !== exp_rd || r_wr !== exp_wr || r_badaddr || r_strobe || (exp_wr && r_wseen !== exp_wd)) begin
        errors++;
        $display("FAIL rand_mem[%0d] a=%h: got rd=%b wr=%b wd=%h badaddr=%b strobe_bad=%b exp %b/%b/%h",
                 n, addr, r_rd, r_wr, r_wseen, r_badaddr, r_strobe, exp_rd, exp_wr, exp_wd);
      end
    end
  endtask

  initial begin
    test_reset;
    test_word_access;
    test_byte_access;
    test_misaligned;
    test_reset_mid;
    test_bounds;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
